// File: rtl/mic_rec_ctrl_pkg.sv
// Shared definitions for the microphone record/playback sequencer.
// Holds the state encoding, default parameter values and width helpers.
package mic_rec_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2
  } state_t;

  localparam int DEF_CLK_DIV       = 4;
  localparam int DEF_BITS_PER_WORD = 8;
  localparam int DEF_DEPTH         = 16;
  localparam int DEF_PLAY_DIV      = 32;

  function automatic int countWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int ctrWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mic_rec_ctrl_clk_gen.sv
// Microphone bit-clock divider: micClk toggles every CLK_DIV clks while enabled.
// o_rise marks the clk cycle in which micClk goes 0->1.
module mic_clk_gen
  import mic_rec_ctrl_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_micClk,
  output logic o_rise
);

  localparam int CW = ctrWidth(CLK_DIV);

  logic [CW-1:0] r_div;
  logic          r_micClk;
  logic          w_term;

  assign w_term = (r_div == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div    <= '0;
      r_micClk <= 1'b0;
    end else if (!i_en) begin
      r_div    <= '0;
      r_micClk <= 1'b0;
    end else if (w_term) begin
      r_div    <= '0;
      r_micClk <= ~r_micClk;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  // Gating with the enable drops micClk in the same cycle the sequencer leaves REC.
  assign o_micClk = r_micClk & i_en;
  assign o_rise   = i_en & w_term & ~r_micClk;

endmodule

// File: rtl/mic_rec_ctrl.sv
// Record/playback sequencer for the microfono buffer: packs PDM bits into words,
// paces playback reads and tracks buffer occupancy (full/empty) internally.
module mic_rec_ctrl
  import mic_rec_ctrl_pkg::*;
#(
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int BITS_PER_WORD = DEF_BITS_PER_WORD,
  parameter int DEPTH         = DEF_DEPTH,
  parameter int PLAY_DIV      = DEF_PLAY_DIV
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rec,
  input  logic                           play,
  input  logic                           micData,
  output logic                           micClk,
  output logic                           wr,
  output logic [BITS_PER_WORD-1:0]       dataOut,
  output logic                           rd,
  output logic [countWidth(DEPTH)-1:0]   wordCount,
  output logic                           full,
  output logic                           empty,
  output logic                           busy
);

  localparam int CNTW = countWidth(DEPTH);
  localparam int BW   = ctrWidth(BITS_PER_WORD);
  localparam int TW   = ctrWidth(PLAY_DIV);

  state_t                   r_state, w_nextState;
  logic                     r_recQ, r_playQ;
  logic [BITS_PER_WORD-2:0] r_shift;
  logic [BW-1:0]            r_bitCnt;
  logic [TW-1:0]            r_playTimer;
  logic                     r_wr, r_rd, r_full, r_empty, r_busy;
  logic [BITS_PER_WORD-1:0] r_dataOut;
  logic [CNTW-1:0]          r_wordCount;

  logic w_recRise, w_recFall, w_playRise, w_playFall;
  logic w_rise, w_wordDone, w_playTick, w_lastWord, w_lastRead;
  logic [BITS_PER_WORD-1:0] w_nextWord;

  mic_clk_gen #(.CLK_DIV(CLK_DIV)) u_clkGen (
    .clk      (clk),
    .reset    (reset),
    .i_en     (r_state == REC),
    .o_micClk (micClk),
    .o_rise   (w_rise)
  );

  assign w_recRise  = rec & ~r_recQ;
  assign w_recFall  = ~rec & r_recQ;
  assign w_playRise = play & ~r_playQ;
  assign w_playFall = ~play & r_playQ;

  assign w_nextWord = {r_shift, micData};
  assign w_wordDone = (r_state == REC) & w_rise & (r_bitCnt == BW'(BITS_PER_WORD - 1));
  assign w_playTick = (r_state == PLAY) & (r_playTimer == TW'(PLAY_DIV - 1));
  assign w_lastWord = (r_wordCount == CNTW'(DEPTH - 1));
  assign w_lastRead = (r_wordCount == CNTW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_recQ  <= 1'b0;
      r_playQ <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_recQ  <= rec;
      r_playQ <= play;
      r_busy  <= (w_nextState != IDLE);
    end
  end

  // Aborts take priority over a word or read completing in the same cycle.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_recRise && !r_full)        w_nextState = REC;
        else if (w_playRise && !r_empty) w_nextState = PLAY;
      end
      REC: begin
        if (w_recFall)                     w_nextState = IDLE;
        else if (w_wordDone && w_lastWord) w_nextState = IDLE;
      end
      PLAY: begin
        if (w_playFall)                    w_nextState = IDLE;
        else if (w_playTick && w_lastRead) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift     <= '0;
      r_bitCnt    <= '0;
      r_playTimer <= '0;
    end else begin
      if (r_state != REC || w_recFall) begin
        r_shift  <= '0;
        r_bitCnt <= '0;
      end else if (w_rise) begin
        r_shift  <= w_nextWord[BITS_PER_WORD-2:0];
        r_bitCnt <= w_wordDone ? '0 : r_bitCnt + 1'b1;
      end
      if (r_state == PLAY && !w_playFall && !w_playTick) r_playTimer <= r_playTimer + 1'b1;
      else                                               r_playTimer <= '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_dataOut   <= '0;
      r_wordCount <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
    end else begin
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      if (w_wordDone && !w_recFall) begin
        r_wr        <= 1'b1;
        r_dataOut   <= w_nextWord;
        r_wordCount <= r_wordCount + 1'b1;
        r_full      <= w_lastWord;
        r_empty     <= 1'b0;
      end else if (w_playTick && !w_playFall) begin
        r_rd        <= 1'b1;
        r_wordCount <= r_wordCount - 1'b1;
        r_empty     <= w_lastRead;
        r_full      <= 1'b0;
      end
    end
  end

  assign wr        = r_wr;
  assign rd        = r_rd;
  assign dataOut   = r_dataOut;
  assign wordCount = r_wordCount;
  assign full      = r_full;
  assign empty     = r_empty;
  assign busy      = r_busy;

endmodule

// File: tb/tb_mic_rec_ctrl.sv
// Scoreboard bench for mic_rec_ctrl: expected wr/rd transactions are queued by
// the stimulus and checked by a monitor whenever the DUT strobes wr or rd.
module tb_mic_rec_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       rec;
  logic       play;
  logic       micData;
  logic       micClk;
  logic       wr;
  logic [7:0] dataOut;
  logic       rd;
  logic [4:0] wordCount;
  logic       full;
  logic       empty;
  logic       busy;

  mic_rec_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .rec       (rec),
    .play      (play),
    .micData   (micData),
    .micClk    (micClk),
    .wr        (wr),
    .dataOut   (dataOut),
    .rd        (rd),
    .wordCount (wordCount),
    .full      (full),
    .empty     (empty),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic [4:0] count;
  } wrExp_t;

  wrExp_t     wrQ[$];
  logic [4:0] rdQ[$];
  int         wrCycles[$];
  int         rdCycles[$];
  int         cyc = 0;
  int         nChecks = 0;
  int         nPass = 0;
  logic       altMode = 1'b0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic recV, input logic playV);
    @(posedge clk);
    #1;
    rec  = recV;
    play = playV;
  endtask

  task automatic waitWr(input int target, input int budget, input string name);
    for (int k = 0; k < budget && wrCycles.size() < target; k++) @(posedge clk);
    checkOutput(name, wrCycles.size(), target);
  endtask

  task automatic waitRd(input int target, input int budget, input string name);
    for (int k = 0; k < budget && rdCycles.size() < target; k++) @(posedge clk);
    checkOutput(name, rdCycles.size(), target);
  endtask

  task automatic waitMicRises(input int n, input int budget, output int got,
                              output int firstCyc, output int lastCyc);
    logic prev;
    prev     = micClk;
    got      = 0;
    firstCyc = 0;
    lastCyc  = 0;
    for (int k = 0; k < budget && got < n; k++) begin
      @(negedge clk);
      if (micClk && !prev) begin
        got++;
        if (got == 1) firstCyc = cyc;
        lastCyc = cyc;
      end
      prev = micClk;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_micClk"}, micClk, 0);
    checkOutput({tag, "_wr"}, wr, 0);
    checkOutput({tag, "_rd"}, rd, 0);
    checkOutput({tag, "_dataOut"}, dataOut, 0);
    checkOutput({tag, "_wordCount"}, wordCount, 0);
    checkOutput({tag, "_full"}, full, 0);
    checkOutput({tag, "_empty"}, empty, 1);
    checkOutput({tag, "_busy"}, busy, 0);
  endtask

  // Alternating pattern: flip micData just after each sampled micClk rise.
  always @(posedge micClk) begin
    if (altMode) begin
      #1;
      micData = ~micData;
    end
  end

  always @(negedge clk) begin : monitor
    wrExp_t e;
    if (!reset) begin
      if (wr && rd) begin
        nChecks++;
        $display("[TB] FAIL wr_rd_overlap: wr=%0b rd=%0b, expected never both", wr, rd);
      end
      if (wr) begin
        wrCycles.push_back(cyc);
        if (wrQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected_wr: dataOut=%0h wordCount=%0d, expected no wr",
                   dataOut, wordCount);
        end else begin
          e = wrQ.pop_front();
          checkOutput("wr_dataOut", dataOut, e.data);
          checkOutput("wr_wordCount", wordCount, e.count);
        end
      end
      if (rd) begin
        rdCycles.push_back(cyc);
        if (rdQ.size() == 0) begin
          nChecks++;
          $display("[TB] FAIL unexpected_rd: wordCount=%0d, expected no rd", wordCount);
        end else begin
          checkOutput("rd_wordCount", wordCount, rdQ.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int startCyc, got, c1, c2, base, rdBase;

    reset   = 1'b1;
    rec     = 1'b0;
    play    = 1'b0;
    micData = 1'b1;
    #7;
    checkResetValues("reset");
    #3;
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("idle_micClk", micClk, 0);
    checkOutput("idle_busy", busy, 0);

    $display("[TB] record until full");
    wrQ.push_back('{8'hFF, 5'd1});
    for (int i = 2; i <= 16; i++) wrQ.push_back('{8'hAA, i[4:0]});
    applyStimulus(1'b1, 1'b0);
    startCyc = cyc;
    waitWr(1, 120, "first_wr_seen");
    altMode = 1'b1;
    micData = 1'b1;
    if (wrCycles.size() >= 1) begin
      checkOutput("first_wr_latency_ok",
                  (wrCycles[0] - startCyc >= 56) && (wrCycles[0] - startCyc <= 72), 1);
    end
    waitMicRises(2, 40, got, c1, c2);
    checkOutput("micClk_rises_seen", got, 2);
    checkOutput("micClk_period", c2 - c1, 8);
    waitWr(16, 16 * 64 + 200, "all_16_wr_seen");
    if (wrCycles.size() >= 16) begin
      checkOutput("wr_spacing_first", wrCycles[1] - wrCycles[0], 64);
      checkOutput("wr_spacing_last", wrCycles[15] - wrCycles[14], 64);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("full_after_16", full, 1);
    checkOutput("full_empty", empty, 0);
    checkOutput("full_busy", busy, 0);
    checkOutput("full_micClk", micClk, 0);
    checkOutput("full_wordCount", wordCount, 16);
    repeat (100) @(posedge clk);
    checkOutput("no_17th_wr", wrCycles.size(), 16);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rec_while_full_busy", busy, 0);
    repeat (80) @(posedge clk);
    checkOutput("rec_while_full_no_wr", wrCycles.size(), 16);
    applyStimulus(1'b0, 1'b0);
    altMode = 1'b0;
    micData = 1'b1;

    $display("[TB] playback until empty");
    for (int i = 15; i >= 0; i--) rdQ.push_back(i[4:0]);
    applyStimulus(1'b0, 1'b1);
    startCyc = cyc;
    waitRd(16, 16 * 32 + 100, "all_16_rd_seen");
    if (rdCycles.size() >= 16) begin
      checkOutput("first_rd_latency_ok",
                  (rdCycles[0] - startCyc >= 32) && (rdCycles[0] - startCyc <= 33), 1);
      checkOutput("rd_spacing_first", rdCycles[1] - rdCycles[0], 32);
      checkOutput("rd_spacing_last", rdCycles[15] - rdCycles[14], 32);
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("empty_after_play", empty, 1);
    checkOutput("play_busy", busy, 0);
    checkOutput("play_wordCount", wordCount, 0);
    checkOutput("play_no_wr", wrCycles.size(), 16);
    applyStimulus(1'b0, 1'b0);

    $display("[TB] mixed cases");
    base = wrCycles.size();
    for (int i = 1; i <= 3; i++) wrQ.push_back('{8'hFF, i[4:0]});
    applyStimulus(1'b1, 1'b0);
    waitWr(base + 3, 300, "three_wr_seen");
    applyStimulus(1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("three_wordCount", wordCount, 3);
    checkOutput("three_busy", busy, 0);
    rdBase = rdCycles.size();
    applyStimulus(1'b1, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("both_edges_busy", busy, 1);
    waitMicRises(5, 100, got, c1, c2);
    checkOutput("both_edges_rec_bits", got, 5);
    applyStimulus(1'b0, 1'b0);
    repeat (80) @(posedge clk);
    #1;
    checkOutput("abort_wordCount", wordCount, 3);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_no_wr", wrCycles.size(), base + 3);
    checkOutput("both_edges_no_rd", rdCycles.size(), rdBase);

    applyStimulus(1'b1, 1'b0);
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkResetValues("midword_reset");
    #4;
    reset = 1'b0;
    rec   = 1'b0;
    repeat (5) @(posedge clk);
    checkOutput("wrQ_drained", wrQ.size(), 0);
    checkOutput("rdQ_drained", rdQ.size(), 0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
